// File: rtl/decode_hazard_scheduler_if.sv
// Decode-to-execute issue bundle for decode_hazard_scheduler.
// The master drives decode requests; the slave returns stall/issue and retirement status.
interface decode_hazard_scheduler_if #(
  parameter int unsigned NUM_REGS          = 32,
  parameter int unsigned STALL_COUNT_WIDTH = 16
);
  logic                         decode_valid;
  logic [4:0]                   decode_rs;
  logic [4:0]                   decode_rt;
  logic                         decode_uses_rt;
  logic [4:0]                   decode_dest;
  logic                         decode_dest_write;
  logic                         execute_ready;
  logic                         flush;
  logic                         stall;
  logic                         issue;
  logic                         writeback_valid;
  logic [4:0]                   writeback_index;
  logic [NUM_REGS-1:0]          busy_vector;
  logic [STALL_COUNT_WIDTH-1:0] stall_cycles;

  modport master (
    output decode_valid, decode_rs, decode_rt, decode_uses_rt,
           decode_dest, decode_dest_write, execute_ready, flush,
    input  stall, issue, writeback_valid, writeback_index,
           busy_vector, stall_cycles
  );

  modport slave (
    input  decode_valid, decode_rs, decode_rt, decode_uses_rt,
           decode_dest, decode_dest_write, execute_ready, flush,
    output stall, issue, writeback_valid, writeback_index,
           busy_vector, stall_cycles
  );
endinterface

// File: rtl/decode_hazard_scheduler.sv
// Scoreboard issue controller: per-register countdowns, RAW/WAW stall, writeback pulses.
// Optional DECODE_BYPASS_EN: a source whose write retires this cycle does not stall.
module decode_hazard_scheduler #(
  parameter int unsigned NUM_REGS          = 32,
  parameter int unsigned WRITEBACK_LATENCY = 3,
  parameter int unsigned COUNTER_WIDTH     = 3,
  parameter int unsigned STALL_COUNT_WIDTH = 16
) (
  input logic                      clock,
  input logic                      reset,
  decode_hazard_scheduler_if.slave bus
);
  localparam int unsigned IDX_W = 5;
  localparam logic [COUNTER_WIDTH-1:0] LOAD_VAL = COUNTER_WIDTH'(WRITEBACK_LATENCY);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0]     cnt_q [NUM_REGS];
  logic [COUNTER_WIDTH-1:0]     cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0]          busy;
  logic [NUM_REGS-1:0]          last_cycle;
  logic [NUM_REGS-1:0]          raw_busy;
  logic                         hazard;
  logic                         stall_c;
  logic                         issue_c;
  logic                         load;
  logic                         wb_valid_q, wb_valid_d;
  logic [IDX_W-1:0]             wb_index_q, wb_index_d;
  logic [STALL_COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Register 0 is hardwired not-busy regardless of counter contents.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      busy[i]       = (i != 0) && (cnt_q[i] != '0);
      last_cycle[i] = (i != 0) && (cnt_q[i] == CNT_ONE);
    end
  end

`ifdef DECODE_BYPASS_EN
  assign raw_busy = busy & ~last_cycle;
`else
  assign raw_busy = busy;
`endif

  assign hazard  = raw_busy[bus.decode_rs]
                 | (bus.decode_uses_rt    & raw_busy[bus.decode_rt])
                 | (bus.decode_dest_write & busy[bus.decode_dest]);
  assign stall_c = bus.decode_valid & (hazard | ~bus.execute_ready);
  assign issue_c = bus.decode_valid & ~stall_c;
  assign load    = issue_c & bus.decode_dest_write & (bus.decode_dest != '0);

  // Countdown update; WAW stalls guarantee at most one counter sits at 1 per cycle.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_index_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i == 0) begin
        cnt_d[i] = '0;
      end else if (load && (bus.decode_dest == IDX_W'(i))) begin
        cnt_d[i] = LOAD_VAL;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
      if (last_cycle[i]) begin
        wb_valid_d = 1'b1;
        wb_index_d = IDX_W'(i);
      end
    end
    if (bus.flush) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt_d[i] = '0;
      end
      wb_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      wb_valid_q  <= 1'b0;
      wb_index_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      wb_valid_q  <= wb_valid_d;
      wb_index_q  <= wb_index_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall           = stall_c;
  assign bus.issue           = issue_c;
  assign bus.writeback_valid = wb_valid_q;
  assign bus.writeback_index = wb_index_q;
  assign bus.busy_vector     = busy;
  assign bus.stall_cycles    = stall_cnt_q;
endmodule
